// File: rtl/packet_demux.sv
// packet_demux: reassembles INPUT_WORDS-word items from a header/payload word stream
// and routes each item to a per-channel single-entry output register.
// Optional feature: define PACKET_DEMUX_ERR_COUNT_EN to add a saturating 16-bit
// err_count port that counts discarded invalid header words.
module packet_demux #(
    parameter int CHANNEL_COUNT = 4,
    parameter int WORD_SIZE = 8,
    parameter int INPUT_WORDS = 2,
    parameter int SEGMENT_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER_TEMPLATE = 8'h80,
    parameter int HEADER_COUNT_SHIFT = 0,
    parameter int HEADER_CHANNEL_SHIFT = 4,
    parameter int HEADER_END_SHIFT = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic [CHANNEL_COUNT-1:0] out_valid,
    input  logic [CHANNEL_COUNT-1:0] out_ready,
    output logic [CHANNEL_COUNT-1:0] out_end,
    output logic [CHANNEL_COUNT*INPUT_WORDS*WORD_SIZE-1:0] out_data
`ifdef PACKET_DEMUX_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);
    localparam int CW = $clog2(SEGMENT_SIZE) + 1;
    localparam int HW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
    localparam int IWW = INPUT_WORDS > 1 ? $clog2(INPUT_WORDS) : 1;
    localparam int ITEM_W = INPUT_WORDS * WORD_SIZE;
    localparam int SW = ITEM_W - WORD_SIZE;
    localparam logic [WORD_SIZE-1:0] FIELD_MASK = HEADER_TEMPLATE
        | WORD_SIZE'(((1 << CW) - 1) << HEADER_COUNT_SHIFT)
        | WORD_SIZE'(((1 << HW) - 1) << HEADER_CHANNEL_SHIFT)
        | WORD_SIZE'(1 << HEADER_END_SHIFT);

    typedef enum logic {SYNC, PAYLOAD} state_t;

    state_t state, state_next;
    logic [HW-1:0] ch;
    logic [CW-1:0] cnt;
    logic seg_end;
    logic [IWW-1:0] word_idx;
    logic [CW-1:0] item_idx;
    logic [SW-1:0] shift_reg;
    logic [CW-1:0] hdr_cnt;
    logic [HW-1:0] hdr_ch;
    logic hdr_end, hdr_ok, accept, last_word, last_item, complete;
    logic [ITEM_W-1:0] item;

    assign hdr_cnt = in_data[HEADER_COUNT_SHIFT +: CW];
    assign hdr_ch = in_data[HEADER_CHANNEL_SHIFT +: HW];
    assign hdr_end = in_data[HEADER_END_SHIFT];
    assign hdr_ok = ((in_data & HEADER_TEMPLATE) == HEADER_TEMPLATE) && hdr_cnt != '0
        && 32'(hdr_cnt) <= SEGMENT_SIZE && 32'(hdr_ch) < CHANNEL_COUNT
        && (in_data & ~FIELD_MASK) == '0;
    assign accept = in_valid && in_ready;
    assign last_word = state == PAYLOAD && word_idx == IWW'(INPUT_WORDS - 1);
    assign last_item = item_idx == cnt - CW'(1);
    assign complete = accept && last_word;
    // The first word of an item ends up most significant.
    assign item = {shift_reg, in_data};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= SYNC;
        else state <= state_next;
    end

    // Next state: a valid header opens a segment, its last item closes it.
    always_comb begin
        state_next = !accept ? state
                   : state == SYNC ? (hdr_ok ? PAYLOAD : SYNC)
                   : (last_word && last_item ? SYNC : PAYLOAD);
    end

    // Stall only the word that would complete an item into a full, unpopped register.
    always_comb begin
        in_ready = !(last_word && out_valid[ch] && !out_ready[ch]);
    end

    // Header context, word/item counters and the item assembly register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch <= '0;
            cnt <= '0;
            seg_end <= 1'b0;
            word_idx <= '0;
            item_idx <= '0;
            shift_reg <= '0;
        end else if (accept && state == SYNC) begin
            if (hdr_ok) begin
                ch <= hdr_ch;
                cnt <= hdr_cnt;
                seg_end <= hdr_end;
                word_idx <= '0;
                item_idx <= '0;
            end
        end else if (accept) begin
            shift_reg <= item[SW-1:0];
            word_idx <= last_word ? '0 : word_idx + IWW'(1);
            item_idx <= last_word ? item_idx + CW'(1) : item_idx;
        end
    end

    // Per-channel output registers: a load wins over a simultaneous pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_end <= '0;
            out_data <= '0;
        end else begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                if (complete && ch == HW'(c)) begin
                    out_valid[c] <= 1'b1;
                    out_end[c] <= seg_end && last_item;
                    out_data[c*ITEM_W +: ITEM_W] <= item;
                end else if (out_valid[c] && out_ready[c]) begin
                    out_valid[c] <= 1'b0;
                    out_end[c] <= 1'b0;
                    out_data[c*ITEM_W +: ITEM_W] <= '0;
                end
            end
        end
    end

`ifdef PACKET_DEMUX_ERR_COUNT_EN
    // Saturating count of discarded header words.
    always_ff @(posedge clk) begin
        if (!rst_n) err_count <= '0;
        else if (accept && state == SYNC && !hdr_ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`endif
endmodule
